// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and phase-decode helpers for the baud tick generator.
package uart_pkg;

    localparam int unsigned OSR_16  = 16;
    localparam int unsigned OSR_8   = 8;
    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned PHASE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } baud_state_e;

    // Phase value whose completing os_tick ends the bit.
    function automatic logic [PHASE_W-1:0] osr_last(input logic osr8);
        return osr8 ? PHASE_W'(OSR_8 - 1) : PHASE_W'(OSR_16 - 1);
    endfunction

    // Phase value whose completing os_tick marks mid-bit.
    function automatic logic [PHASE_W-1:0] osr_mid(input logic osr8);
        return osr8 ? PHASE_W'(OSR_8 / 2 - 1) : PHASE_W'(OSR_16 / 2 - 1);
    endfunction

endpackage

// File: rtl/frac_prescaler.sv
// Fractional prescaler: period of div_int (+1 on accumulator carry) clocks, registered os_tick.
module frac_prescaler #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              wrap_o,
    output logic              os_tick_o
);

    localparam int unsigned CNT_W = DIV_W + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lim_q, lim_d;
    logic [CNT_W-1:0]  lim_next;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W:0]   sum;
    logic              tick_q, tick_d;

    always_comb begin
        // A restart begins from a clean accumulator.
        acc_base = start_i ? '0 : acc_q;
        sum      = {1'b0, acc_base} + {1'b0, div_frac_i};
        lim_next = {1'b0, div_int_i} + CNT_W'(sum[FRAC_W]) - CNT_W'(1);
        wrap_o   = !clear_i && !start_i && (cnt_q == lim_q);

        cnt_d  = cnt_q;
        lim_d  = lim_q;
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            lim_d = '0;
            acc_d = '0;
        end else if (start_i || wrap_o) begin
            // Period start: latch the divisor for the whole coming period.
            cnt_d  = '0;
            lim_d  = lim_next;
            acc_d  = sum[FRAC_W-1:0];
            tick_d = wrap_o;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lim_q  <= '0;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign os_tick_o = tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud tick generator: run/error FSM, oversample phase counter and mid/end-of-bit strobes.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              osr_sel,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);

    baud_state_e        state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               osr8_q, osr8_d;
    logic               mid_q, mid_d;
    logic               bit_q, bit_d;
    logic               cfg_err_q, cfg_err_d;
    logic               div_ok;
    logic               run_next;
    logic               start;
    logic               clear;
    logic               wrap;

    assign div_ok = (div_int >= DIV_W'(MIN_DIV));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (en) state_d = div_ok ? StRun : StErr;
            end
            StRun: begin
                if (!en)         state_d = StIdle;
                else if (!div_ok) state_d = StErr;
            end
            StErr: begin
                if (!en)        state_d = StIdle;
                else if (div_ok) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    // resync only restarts the bit phase while already running.
    assign run_next = (state_d == StRun);
    assign start    = run_next && ((state_q != StRun) || resync);
    assign clear    = !run_next;

    frac_prescaler #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .start_i    (start),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .wrap_o     (wrap),
        .os_tick_o  (os_tick)
    );

    always_comb begin
        phase_d   = phase_q;
        osr8_d    = osr8_q;
        mid_d     = 1'b0;
        bit_d     = 1'b0;
        cfg_err_d = (state_d == StErr);
        if (clear) begin
            phase_d = '0;
            osr8_d  = 1'b0;
        end else if (start) begin
            phase_d = '0;
            osr8_d  = osr_sel;
        end else if (wrap) begin
            // Decode against the ratio latched for the period just completed.
            osr8_d = osr_sel;
            mid_d  = (phase_q == osr_mid(osr8_q));
            if (phase_q >= osr_last(osr8_q)) begin
                phase_d = '0;
                bit_d   = 1'b1;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            osr8_q    <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            osr8_q    <= osr8_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign cfg_err  = cfg_err_q;

endmodule
